// File: rtl/tx_lane_framer_pkg.sv
// Shared symbol constants, forced-symbol codes and framer state encoding.
package tx_lane_framer_pkg;

    localparam logic [7:0] SYM_COM = 8'hBC;
    localparam logic [7:0] SYM_PAD = 8'hF7;
    localparam logic [7:0] SYM_SKP = 8'h1C;
    localparam logic [7:0] SYM_STP = 8'hFB;
    localparam logic [7:0] SYM_SDP = 8'h5C;
    localparam logic [7:0] SYM_END = 8'hFD;
    localparam logic [7:0] SYM_EDB = 8'hFE;
    localparam logic [7:0] SYM_FTS = 8'h3C;
    localparam logic [7:0] SYM_IDL = 8'h7C;

    typedef enum logic [3:0] {
        FS_COM  = 4'd0,
        FS_PAD  = 4'd1,
        FS_SKP  = 4'd2,
        FS_STP  = 4'd3,
        FS_SDP  = 4'd4,
        FS_END  = 4'd5,
        FS_EDB  = 4'd6,
        FS_FTS  = 4'd7,
        FS_IDL  = 4'd8,
        FS_ZERO = 4'd9
    } force_sym_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_ENDW = 2'd2,
        ST_SKPS = 2'd3
    } state_e;

    // One lane symbol together with its control flag.
    typedef struct packed {
        logic       k;
        logic [7:0] sym;
    } ksym_t;

    // Forced-symbol decode; codes above IDL produce a zero data byte.
    function automatic ksym_t force_lookup(input logic [3:0] code);
        ksym_t r;
        r.k = 1'b1;
        case (code)
            FS_COM:  r.sym = SYM_COM;
            FS_PAD:  r.sym = SYM_PAD;
            FS_SKP:  r.sym = SYM_SKP;
            FS_STP:  r.sym = SYM_STP;
            FS_SDP:  r.sym = SYM_SDP;
            FS_END:  r.sym = SYM_END;
            FS_EDB:  r.sym = SYM_EDB;
            FS_FTS:  r.sym = SYM_FTS;
            FS_IDL:  r.sym = SYM_IDL;
            default: begin
                r.k   = 1'b0;
                r.sym = 8'h00;
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/tx_lane_framer_if.sv
// Packet input, force control and lane output bundle of the transmit framer.
interface tx_lane_framer_if #(
    parameter int LANES = 4
);
    logic [8*LANES-1:0] in_data;
    logic               in_valid;
    logic               in_sop;
    logic               in_eop;
    logic               in_type;
    logic               in_err;
    logic               in_ready;
    logic               force_en;
    logic [3:0]         force_sym;
    logic [8*LANES-1:0] out;
    logic [LANES-1:0]   out_k;
    logic               valid;
    logic               drop;

    modport master (
        output in_data, in_valid, in_sop, in_eop, in_type, in_err,
        output force_en, force_sym,
        input  in_ready, out, out_k, valid, drop
    );

    modport slave (
        input  in_data, in_valid, in_sop, in_eop, in_type, in_err,
        input  force_en, force_sym,
        output in_ready, out, out_k, valid, drop
    );
endinterface

// File: rtl/tx_lane_framer_skp_scheduler.sv
// SKP interval timer: raises pending once per interval and holds it until
// the framer consumes it, so several elapsed intervals collapse to one set.
module tx_skp_scheduler #(
    parameter int SKP_INTERVAL = 1180,
    parameter int CW           = 11
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic pending
);
    localparam logic [CW-1:0] LAST = CW'(SKP_INTERVAL - 1);

    logic [CW-1:0] cnt;

    // Count up, flag pending on the edge that reaches LAST, then freeze.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            pending <= 1'b0;
        end else if (clear) begin
            cnt     <= '0;
            pending <= 1'b0;
        end else if (!pending) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST - 1'b1)
                pending <= 1'b1;
        end
    end
endmodule

// File: rtl/tx_lane_framer.sv
// Multi-lane transmit framer: wraps buffer packets in STP/SDP .. END/EDB,
// pads bubbles, idles with IDL, inserts SKP ordered sets between packets and
// supports forced-symbol output. All lane outputs are registered.
module tx_lane_framer
    import tx_lane_framer_pkg::*;
#(
    parameter int LANES        = 4,
    parameter int SKP_INTERVAL = 1180,
    parameter int SKP_LEN      = 3,
    parameter int CW           = 11
) (
    input  logic             clk,
    input  logic             reset,
    tx_lane_framer_if.slave  bus
);
    state_e                  state, state_n;
    logic                    end_err, end_err_n;
    logic [2:0]              skp_cnt, skp_cnt_n;
    logic                    skp_pending, skp_clear;
    ksym_t                   fs;

    logic [LANES-1:0][7:0]   out_r, out_n;
    logic [LANES-1:0]        k_r, k_n;
    logic                    valid_r, valid_n;
    logic                    drop_r, drop_n;

    tx_skp_scheduler #(
        .SKP_INTERVAL (SKP_INTERVAL),
        .CW           (CW)
    ) u_skp (
        .clk     (clk),
        .reset   (reset),
        .clear   (skp_clear),
        .pending (skp_pending)
    );

    // Orphan beats are only taken in IDLE when nothing of higher priority wins.
    assign bus.in_ready = (state == ST_DATA) ||
                          ((state == ST_IDLE) && bus.in_valid && !bus.in_sop &&
                           !bus.force_en && !skp_pending);

    // Next-state and next output word.
    always_comb begin
        state_n   = state;
        end_err_n = end_err;
        skp_cnt_n = skp_cnt;
        skp_clear = 1'b0;
        fs        = force_lookup(bus.force_sym);
        out_n     = {LANES{SYM_IDL}};
        k_n       = '1;
        valid_n   = 1'b0;
        drop_n    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.force_en) begin
                    out_n = {LANES{fs.sym}};
                    k_n   = {LANES{fs.k}};
                end else if (skp_pending) begin
                    out_n     = {LANES{SYM_COM}};
                    skp_clear = 1'b1;
                    skp_cnt_n = '0;
                    state_n   = ST_SKPS;
                end else if (bus.in_valid && bus.in_sop) begin
                    // Start word only; the SOP beat stays held upstream.
                    out_n    = {LANES{SYM_PAD}};
                    out_n[0] = bus.in_type ? SYM_SDP : SYM_STP;
                    valid_n  = 1'b1;
                    state_n  = ST_DATA;
                end else if (bus.in_valid) begin
                    drop_n = 1'b1;
                end
            end
            ST_DATA: begin
                if (bus.in_valid) begin
                    out_n   = bus.in_data;
                    k_n     = '0;
                    valid_n = 1'b1;
                    if (bus.in_eop) begin
                        end_err_n = bus.in_err;
                        state_n   = ST_ENDW;
                    end
                end else begin
                    out_n = {LANES{SYM_PAD}};
                end
            end
            ST_ENDW: begin
                out_n    = {LANES{SYM_PAD}};
                out_n[0] = end_err ? SYM_EDB : SYM_END;
                valid_n  = 1'b1;
                state_n  = ST_IDLE;
            end
            ST_SKPS: begin
                out_n = {LANES{SYM_SKP}};
                if (skp_cnt == 3'(SKP_LEN - 1)) begin
                    skp_cnt_n = '0;
                    state_n   = ST_IDLE;
                end else begin
                    skp_cnt_n = skp_cnt + 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // State and registered lane outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            end_err <= 1'b0;
            skp_cnt <= '0;
            out_r   <= '0;
            k_r     <= '0;
            valid_r <= 1'b0;
            drop_r  <= 1'b0;
        end else begin
            state   <= state_n;
            end_err <= end_err_n;
            skp_cnt <= skp_cnt_n;
            out_r   <= out_n;
            k_r     <= k_n;
            valid_r <= valid_n;
            drop_r  <= drop_n;
        end
    end

    assign bus.out   = out_r;
    assign bus.out_k = k_r;
    assign bus.valid = valid_r;
    assign bus.drop  = drop_r;
endmodule

// File: tb/tb_tx_lane_framer.sv
// Bench for tx_lane_framer (4 lanes, SKP every 16 cycles, 3 SKPs per set).
// Lane 0 occupies the low byte of OUT, so a start word reads F7F7F7FB.
module tb_tx_lane_framer;
    localparam int L   = 4;
    localparam int INT = 16;
    localparam int SL  = 3;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    tx_lane_framer_if #(.LANES(L)) bus();

    tx_lane_framer #(
        .LANES(L), .SKP_INTERVAL(INT), .SKP_LEN(SL), .CW(11)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int errors  = 0;
    int checks  = 0;
    bit started = 0;

    // Reference state: what has been promised but not yet sent.
    int   since    = 0;   // cycles since the last SKP set began (or reset)
    int   skp_left = 0;   // SKP words still owed after a COM
    bit   pkt_open = 0;   // inside a packet, waiting for data beats
    bit   end_due  = 0;   // end word owed next cycle
    bit   end_err  = 0;
    logic [31:0] e_out   = '0;
    logic [3:0]  e_k     = '0;
    logic        e_valid = 1'b0;
    logic        e_drop  = 1'b0;

    function automatic logic [31:0] sword(input logic [7:0] s);
        return {s, s, s, s};
    endfunction

    function automatic logic [31:0] fword(input logic [7:0] s);
        return {8'hF7, 8'hF7, 8'hF7, s};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%h expected=%h", name, $time, got, exp);
        end
    endtask

    // Reference model: one output word per clock from the framing rules.
    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            since = 0; skp_left = 0; pkt_open = 0; end_due = 0; end_err = 0;
            e_out = '0; e_k = '0; e_valid = 1'b0; e_drop = 1'b0;
        end else begin
            bit restart;
            logic [7:0] tab [9];
            tab = '{8'hBC, 8'hF7, 8'h1C, 8'hFB, 8'h5C, 8'hFD, 8'hFE, 8'h3C, 8'h7C};
            restart = 0; e_valid = 1'b0; e_drop = 1'b0; e_k = 4'hF;
            if (skp_left > 0) begin
                e_out = sword(8'h1C); skp_left--;
            end else if (end_due) begin
                e_out = fword(end_err ? 8'hFE : 8'hFD); e_valid = 1'b1; end_due = 0;
            end else if (pkt_open) begin
                if (bus.in_valid) begin
                    e_out = bus.in_data; e_k = 4'h0; e_valid = 1'b1;
                    if (bus.in_eop) begin pkt_open = 0; end_due = 1; end_err = bus.in_err; end
                end else begin
                    e_out = sword(8'hF7);
                end
            end else if (bus.force_en) begin
                if (bus.force_sym < 9) e_out = sword(tab[bus.force_sym]);
                else begin e_out = '0; e_k = 4'h0; end
            end else if (since >= INT - 1) begin
                e_out = sword(8'hBC); skp_left = SL; restart = 1;
            end else if (bus.in_valid && bus.in_sop) begin
                e_out = fword(bus.in_type ? 8'h5C : 8'hFB); e_valid = 1'b1; pkt_open = 1;
            end else begin
                e_out = sword(8'h7C); e_drop = bus.in_valid;
            end
            since = restart ? 0 : since + 1;
        end
    end

    function automatic logic exp_ready();
        if (skp_left > 0 || end_due) return 1'b0;
        if (pkt_open) return 1'b1;
        return bus.in_valid && !bus.in_sop && !bus.force_en && !(since >= INT - 1);
    endfunction

    // Compare process: every output on every falling edge.
    initial forever begin
        @(negedge clk);
        if (started) begin
            chk("out",      bus.out,      e_out);
            chk("out_k",    32'(bus.out_k), 32'(e_k));
            chk("valid",    32'(bus.valid), 32'(e_valid));
            chk("drop",     32'(bus.drop),  32'(e_drop));
            chk("in_ready", 32'(bus.in_ready), 32'(exp_ready()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic hword(input string name, input logic [31:0] o, input logic [3:0] k, input logic v);
        chk({name, "_out"}, bus.out, o);
        chk({name, "_k"},   32'(bus.out_k), 32'(k));
        chk({name, "_vld"}, 32'(bus.valid), 32'(v));
    endtask

    task automatic set_beat(input logic [31:0] d, input bit sop, input bit eop, input bit typ, input bit err);
        bus.in_data = d; bus.in_sop = sop; bus.in_eop = eop;
        bus.in_type = typ; bus.in_err = err; bus.in_valid = 1'b1;
    endtask

    // Present one beat and hold it until accepted (bounded).
    task automatic drive_beat(input logic [31:0] d, input bit sop, input bit eop,
                              input bit typ, input bit err, input bit rf);
        bit acc;
        int n;
        acc = 0; n = 0;
        set_beat(d, sop, eop, typ, err);
        while (!acc && n < 300) begin
            if (rf) begin
                bus.force_en  = ($urandom_range(0, 7) == 0);
                bus.force_sym = 4'($urandom_range(0, 15));
            end
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            tick();
            n++;
        end
        bus.in_valid = 1'b0;
        if (rf) bus.force_en = 1'b0;
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL beat_accept t=%0t got=not_accepted expected=accepted", $time);
        end
    endtask

    task automatic idle_cycles(input int n, input bit rf);
        bus.in_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (rf) begin
                bus.force_en  = ($urandom_range(0, 5) == 0);
                bus.force_sym = 4'($urandom_range(0, 15));
            end
            tick();
        end
        bus.force_en = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog t=%0t got=timeout expected=finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_data = '0; bus.in_valid = 0; bus.in_sop = 0; bus.in_eop = 0;
        bus.in_type = 0; bus.in_err = 0; bus.force_en = 0; bus.force_sym = '0;
        #1 reset = 1'b1;
        started = 1;
        tick(); tick();
        hword("reset", 32'h0, 4'h0, 1'b0);
        reset = 1'b0;                                    // released after edge 0

        // Idle from reset: COM at edge 16, three SKPs, next COM at 32.
        tick();           hword("idle_e1", 32'h7C7C7C7C, 4'hF, 1'b0);
        repeat (14) tick(); hword("idle_e15", 32'h7C7C7C7C, 4'hF, 1'b0);
        tick();           hword("com_e16", 32'hBCBCBCBC, 4'hF, 1'b0);
        tick();           hword("skp_e17", 32'h1C1C1C1C, 4'hF, 1'b0);
        tick(); tick();   hword("skp_e19", 32'h1C1C1C1C, 4'hF, 1'b0);
        tick();           hword("idl_e20", 32'h7C7C7C7C, 4'hF, 1'b0);
        repeat (11) tick(); hword("idl_e31", 32'h7C7C7C7C, 4'hF, 1'b0);
        tick();           hword("com_e32", 32'hBCBCBCBC, 4'hF, 1'b0);
        repeat (3) tick(); hword("skp_e35", 32'h1C1C1C1C, 4'hF, 1'b0);
        tick();           hword("idl_e36", 32'h7C7C7C7C, 4'hF, 1'b0);

        // 3-beat TLP without bubbles.
        set_beat(32'h11223344, 1, 0, 0, 0);
        tick();           hword("tlp_stp", 32'hF7F7F7FB, 4'hF, 1'b1);
        tick();           hword("tlp_d0", 32'h11223344, 4'h0, 1'b1);
        set_beat(32'h55667788, 0, 0, 0, 0);
        tick();           hword("tlp_d1", 32'h55667788, 4'h0, 1'b1);
        set_beat(32'h99AABBCC, 0, 1, 0, 0);
        tick();           hword("tlp_d2", 32'h99AABBCC, 4'h0, 1'b1);
        bus.in_valid = 1'b0;
        tick();           hword("tlp_end", 32'hF7F7F7FD, 4'hF, 1'b1);
        tick();           hword("tlp_idl", 32'h7C7C7C7C, 4'hF, 1'b0);

        // Forced symbols in IDLE.
        bus.force_en = 1'b1; bus.force_sym = 4'd7;
        tick();           hword("force_fts", 32'h3C3C3C3C, 4'hF, 1'b0);
        bus.force_sym = 4'd12;
        tick();           hword("force_zero", 32'h00000000, 4'h0, 1'b0);
        bus.force_en = 1'b0;
        tick();

        // Orphan beat is taken and dropped.
        set_beat(32'hDEADBEEF, 0, 0, 0, 0);
        #1 chk("orphan_ready", 32'(bus.in_ready), 32'd1);
        tick();           chk("orphan_drop", 32'(bus.drop), 32'd1);
        chk("orphan_out", bus.out, 32'h7C7C7C7C);
        bus.in_valid = 1'b0;
        tick();           chk("orphan_drop_clr", 32'(bus.drop), 32'd0);
        tick();           hword("com_e48", 32'hBCBCBCBC, 4'hF, 1'b0);
        repeat (4) tick();

        // 2-beat nullified DLLP with a 2-cycle bubble; FORCE_EN ignored in DATA.
        set_beat(32'h0A0B0C0D, 1, 0, 1, 0);
        tick();           hword("dllp_sdp", 32'hF7F7F75C, 4'hF, 1'b1);
        tick();           hword("dllp_d0", 32'h0A0B0C0D, 4'h0, 1'b1);
        bus.in_valid = 1'b0; bus.force_en = 1'b1; bus.force_sym = 4'd0;
        tick();           hword("dllp_pad0", 32'hF7F7F7F7, 4'hF, 1'b0);
        tick();           hword("dllp_pad1", 32'hF7F7F7F7, 4'hF, 1'b0);
        bus.force_en = 1'b0;
        set_beat(32'h01020304, 0, 1, 0, 1);
        tick();           hword("dllp_d1", 32'h01020304, 4'h0, 1'b1);
        bus.in_valid = 1'b0; bus.in_err = 1'b0;
        tick();           hword("dllp_edb", 32'hF7F7F7FE, 4'hF, 1'b1);

        // 30-beat packet across an SKP deadline: set follows END, SOP waits.
        for (int b = 0; b < 30; b++)
            drive_beat($urandom(), b == 0, b == 29, 0, 0, 0);
        set_beat(32'hCAFEF00D, 1, 0, 0, 0);
        tick();           hword("long_end", 32'hF7F7F7FD, 4'hF, 1'b1);
        tick();           hword("long_com", 32'hBCBCBCBC, 4'hF, 1'b0);
        tick();           hword("long_skp0", 32'h1C1C1C1C, 4'hF, 1'b0);
        tick(); tick();   hword("long_skp2", 32'h1C1C1C1C, 4'hF, 1'b0);
        tick();           hword("long_stp", 32'hF7F7F7FB, 4'hF, 1'b1);
        drive_beat(32'hCAFEF00D, 1, 1, 0, 0, 0);
        tick();

        // Reset mid-packet clears outputs without a clock edge.
        drive_beat(32'h13579BDF, 1, 0, 0, 0, 0);
        drive_beat(32'h2468ACE0, 0, 0, 0, 0, 0);
        set_beat(32'h0F0F0F0F, 0, 0, 0, 0);
        @(posedge clk); #2;
        reset = 1'b1;
        #1 hword("async_rst", 32'h0, 4'h0, 1'b0);
        chk("async_rst_drop", 32'(bus.drop), 32'd0);
        bus.in_valid = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();           hword("rst_idl", 32'h7C7C7C7C, 4'hF, 1'b0);

        // Randomized traffic: packets, bubbles, orphans, forced symbols.
        for (int p = 0; p < 80; p++) begin
            int kind;
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                drive_beat($urandom(), 0, 0, 0, 0, 1);
            end else if (kind == 1) begin
                idle_cycles($urandom_range(0, 6), 1);
            end else begin
                int n;
                bit typ;
                n   = $urandom_range(1, 6);
                typ = 1'($urandom_range(0, 1));
                for (int b = 0; b < n; b++) begin
                    if (b > 0 && $urandom_range(0, 2) == 0)
                        idle_cycles($urandom_range(1, 3), 1);
                    drive_beat($urandom(), b == 0, b == n - 1, typ,
                               1'($urandom_range(0, 3) == 0), 1);
                end
            end
        end
        idle_cycles(40, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
